bus_ram_target: RTL and testbench
=================================

Name: bus_ram_target

Overview:
- Responder (far-end target) for the on-chip request/ready bus driven by the initiator-side bridges.
- Services single 32-bit word reads and writes against an internal word RAM, with a programmable number of wait states.
- Sits behind a bridge's far port or directly on an interconnect target slot.
- Serves as a scratch memory and as the reference target for verifying bridge/interconnect timing.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, min 2.
- WAIT_STATES, 0, extra cycles inserted between request acceptance and ready; range 0..255.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_request  in  1  access request; initiator holds high until it sees o_ready, then drops it.
- i_rw  in  1  1 = write, 0 = read; valid while i_request is high.
- i_address  in  28  byte address. Bits [1:0] are ignored. Word index = i_address[27:2].
- i_wdata  in  32  write data; valid while i_request is high with i_rw = 1.
- o_rdata  out  32  read data; valid while o_ready is high on a read.
- o_ready  out  1  access complete; held high until i_request drops.
- o_error  out  1  sticky flag, set by any out-of-range access.

Behaviour:
- Reset (i_reset_n = 0 at a clock edge):
  - state = IDLE; o_ready = 0; o_rdata = 0; o_error = 0; wait counter = 0.
  - RAM contents are not cleared and are retained across reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Stay while i_request = 0.
  - When i_request = 1: latch rw, word index and wdata, and load counter = WAIT_STATES.
  - Next state is WAIT if WAIT_STATES > 0, otherwise DONE.
- WAIT:
  - Decrement counter each cycle; go to DONE when the counter reaches 1 → 0 transition.
  - If i_request drops while in WAIT: abort, return to IDLE, no RAM write, o_error unchanged.
- Entering DONE (single cycle, exactly once per accepted access):
  - Write: RAM[index] <= latched wdata.
  - Read: o_rdata <= RAM[index].
  - o_ready <= 1.
- DONE:
  - o_ready and o_rdata stay stable while i_request = 1.
  - When i_request = 0: o_ready <= 0 next edge, return to IDLE. o_rdata holds its last value.
- Latency: o_ready rises WAIT_STATES + 1 cycles after the first edge at which i_request is sampled high in IDLE (WAIT_STATES = 0 gives 1 cycle).
- Address, rw and wdata changes after acceptance are ignored; only the latched values are used.
- Range check: the access is in range iff i_address[27:2] < DEPTH. For an out-of-range access:
  - A write is dropped.
  - A read returns 0x00000000.
  - o_ready is still asserted with normal timing.
  - o_error is set and stays 1 until reset.
- Back-to-back requests:
  - A new request is accepted no earlier than the IDLE cycle following the drop of i_request.
  - Minimum period is WAIT_STATES + 3 cycles.
- Reset mid-access (WAIT or DONE): access abandoned, o_ready = 0 next edge. A write not yet performed is never performed.
- No combinational path from inputs to outputs.

Test Plan:
- WAIT_STATES = 0: write 0xDEADBEEF to address 0x0000010, drop request, then read 0x0000010. Required: o_ready high exactly 1 cycle after each request; read returns 0xDEADBEEF; o_error = 0.
- WAIT_STATES = 3: read address 0x0000013 after writing 0x12345678 to 0x0000010. Required: o_ready rises 4 cycles after request; o_rdata = 0x12345678 (low address bits ignored); o_ready held 5 extra cycles while request is held.
- DEPTH = 1024: write 0xA5A5A5A5 to byte address 0x1000 (word 1024, out of range), then read it. Required: read returns 0; o_error = 1 and stays set. Word 0 is unchanged.
- WAIT_STATES = 4: issue a write to 0x20 with 0x11111111, then drop request after 2 cycles (abort). Required: o_ready never asserts; a later read of 0x20 returns its prior value.
- WAIT_STATES = 2: assert i_reset_n = 0 during WAIT of a write, then release and read the same address. Required: o_ready = 0 the cycle after reset; write not performed; o_rdata = 0 and o_error = 0 after reset.
- Change i_address and i_wdata every cycle after acceptance of a write to 0x40 with 0xCAFEF00D. Required: only 0x40 is written, with 0xCAFEF00D.

Source files
------------

// File: rtl/bus_ram_target.sv
// Word-RAM responder for the request/ready bus with a programmable number of wait states.
// Accepted accesses are latched in IDLE; the RAM is touched exactly once, on the first DONE cycle.
module bus_ram_target #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [27:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_error
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t       state;
    logic [7:0]   count;
    logic         rw;
    logic [AW-1:0] index;
    logic [31:0]  wdata;
    logic         in_range;
    logic         access;
    logic         unused_addr_lsbs;

    logic [31:0]  mem [DEPTH];

    // Byte-lane bits play no part in a word access.
    assign unused_addr_lsbs = &{1'b0, i_address[1:0]};

    // The single cycle in which the latched access is carried out.
    assign access = (state == DONE) && !o_ready && i_request;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            o_ready  <= 1'b0;
            o_rdata  <= 32'd0;
            o_error  <= 1'b0;
            count    <= 8'd0;
            rw       <= 1'b0;
            index    <= '0;
            wdata    <= 32'd0;
            in_range <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_request) begin
                        rw       <= i_rw;
                        index    <= i_address[AW+1:2];
                        wdata    <= i_wdata;
                        in_range <= {6'd0, i_address[27:2]} < 32'(DEPTH);
                        count    <= 8'(WAIT_STATES);
                        state    <= (WAIT_STATES > 0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (!i_request) begin
                        count <= 8'd0;
                        state <= IDLE;
                    end else begin
                        count <= count - 8'd1;
                        if (count == 8'd1)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (!o_ready) begin
                        // A request withdrawn before completion is treated as an abort.
                        if (!i_request) begin
                            state <= IDLE;
                        end else begin
                            o_ready <= 1'b1;
                            if (!rw)
                                o_rdata <= in_range ? mem[index] : 32'd0;
                            if (!in_range)
                                o_error <= 1'b1;
                        end
                    end else if (!i_request) begin
                        o_ready <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM has no reset so contents survive i_reset_n; a pending write is cancelled by it.
    always_ff @(posedge i_clock) begin
        if (i_reset_n && access && rw && in_range)
            mem[index] <= wdata;
    end

endmodule

// File: tb/tb_bus_ram_target.sv
// Directed bench for bus_ram_target: four instances with different wait-state settings,
// each exercised by a linear sequence of hand-computed accesses.
module tb_bus_ram_target;
    localparam int N = 4;
    // Instance k uses WAIT_STATES = WS_TAB[k*8 +: 8]: 0, 3, 4, 2.
    localparam logic [31:0] WS_TAB = {8'd2, 8'd4, 8'd3, 8'd0};

    logic        clk = 1'b0;
    logic        rst_n [N];
    logic        req   [N];
    logic        rw    [N];
    logic [27:0] addr  [N];
    logic [31:0] wd    [N];
    logic [31:0] rd    [N];
    logic        rdy   [N];
    logic        err   [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_ram_target #(
            .DEPTH      (1024),
            .WAIT_STATES(int'(WS_TAB[g*8 +: 8]))
        ) u_dut (
            .i_clock  (clk),
            .i_reset_n(rst_n[g]),
            .i_request(req[g]),
            .i_rw     (rw[g]),
            .i_address(addr[g]),
            .i_wdata  (wd[g]),
            .o_rdata  (rd[g]),
            .o_ready  (rdy[g]),
            .o_error  (err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete handshake; lat = edges from acceptance to o_ready visible.
    task automatic access(input int k, input logic w, input logic [27:0] a, input logic [31:0] d,
                          input int hold, input bit churn, output logic [31:0] data, output int lat);
        int n;
        logic [31:0] first;
        @(negedge clk);
        req[k] = 1'b1; rw[k] = w; addr[k] = a; wd[k] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (churn && !rdy[k]) begin
                addr[k] = (n % 2 == 1) ? 28'h44 : 28'h48;
                wd[k]   = $urandom;
            end
        end while (!rdy[k] && n < 60);
        if (n >= 60) check("ready_timeout", 32'(rdy[k]), 32'd1);
        lat   = n - 1;
        data  = rd[k];
        first = rd[k];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ready_held", 32'(rdy[k]), 32'd1);
            check("rdata_stable", rd[k], first);
        end
        req[k] = 1'b0;
        @(negedge clk);
        check("ready_fall", 32'(rdy[k]), 32'd0);
        check("rdata_keep", rd[k], first);
    endtask

    initial begin
        logic [31:0] data;
        int lat;

        for (int k = 0; k < N; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wd[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_ready", 32'(rdy[k]), 32'd0);
            check("rst_rdata", rd[k], 32'd0);
            check("rst_error", 32'(err[k]), 32'd0);
        end

        // WAIT_STATES = 0: write then read back.
        access(0, 1'b1, 28'h10, 32'hDEADBEEF, 0, 1'b0, data, lat);
        check("ws0_wr_lat", lat, 32'd1);
        access(0, 1'b0, 28'h10, 32'h0, 0, 1'b0, data, lat);
        check("ws0_rd_lat", lat, 32'd1);
        check("ws0_rd_data", data, 32'hDEADBEEF);
        check("ws0_error", 32'(err[0]), 32'd0);

        // WAIT_STATES = 3: low address bits ignored, ready held while request held.
        access(1, 1'b1, 28'h10, 32'h12345678, 0, 1'b0, data, lat);
        check("ws3_wr_lat", lat, 32'd4);
        access(1, 1'b0, 28'h13, 32'h0, 5, 1'b0, data, lat);
        check("ws3_rd_lat", lat, 32'd4);
        check("ws3_rd_data", data, 32'h12345678);

        // Out of range: word 1024 must not alias word 0.
        access(0, 1'b1, 28'h0, 32'h0BADF00D, 0, 1'b0, data, lat);
        check("oor_pre_error", 32'(err[0]), 32'd0);
        access(0, 1'b1, 28'h1000, 32'hA5A5A5A5, 0, 1'b0, data, lat);
        check("oor_wr_lat", lat, 32'd1);
        check("oor_wr_error", 32'(err[0]), 32'd1);
        access(0, 1'b0, 28'h1000, 32'h0, 0, 1'b0, data, lat);
        check("oor_rd_data", data, 32'h0);
        access(0, 1'b0, 28'h0, 32'h0, 0, 1'b0, data, lat);
        check("oor_word0", data, 32'h0BADF00D);
        check("oor_error_sticky", 32'(err[0]), 32'd1);

        // WAIT_STATES = 4: write aborted after two cycles.
        access(2, 1'b1, 28'h20, 32'h77777777, 0, 1'b0, data, lat);
        check("ws4_wr_lat", lat, 32'd5);
        @(negedge clk);
        req[2] = 1'b1; rw[2] = 1'b1; addr[2] = 28'h20; wd[2] = 32'h11111111;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ready", 32'(rdy[2]), 32'd0);
        end
        req[2] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_idle_ready", 32'(rdy[2]), 32'd0);
        end
        access(2, 1'b0, 28'h20, 32'h0, 0, 1'b0, data, lat);
        check("abort_rd_data", data, 32'h77777777);
        check("abort_error", 32'(err[2]), 32'd0);

        // WAIT_STATES = 2: reset during the WAIT of a write.
        access(3, 1'b1, 28'h30, 32'h55555555, 0, 1'b0, data, lat);
        check("ws2_wr_lat", lat, 32'd3);
        access(3, 1'b0, 28'h30, 32'h0, 0, 1'b0, data, lat);
        check("ws2_rd_data", data, 32'h55555555);
        @(negedge clk);
        req[3] = 1'b1; rw[3] = 1'b1; addr[3] = 28'h30; wd[3] = 32'h99999999;
        @(negedge clk);
        rst_n[3] = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(rdy[3]), 32'd0);
        check("midrst_rdata", rd[3], 32'd0);
        check("midrst_error", 32'(err[3]), 32'd0);
        req[3] = 1'b0;
        @(negedge clk);
        rst_n[3] = 1'b1;
        @(negedge clk);
        access(3, 1'b0, 28'h30, 32'h0, 0, 1'b0, data, lat);
        check("midrst_rd_data", data, 32'h55555555);

        // Inputs churning after acceptance must not affect the write.
        access(1, 1'b1, 28'h44, 32'h01010101, 0, 1'b0, data, lat);
        access(1, 1'b1, 28'h40, 32'hCAFEF00D, 0, 1'b1, data, lat);
        check("churn_wr_lat", lat, 32'd4);
        access(1, 1'b0, 28'h40, 32'h0, 0, 1'b0, data, lat);
        check("churn_rd_40", data, 32'hCAFEF00D);
        access(1, 1'b0, 28'h44, 32'h0, 0, 1'b0, data, lat);
        check("churn_rd_44", data, 32'h01010101);
        check("churn_error", 32'(err[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
